// File: rtl/mux_piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
package mux_piso_serializer_pkg;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Map the bit counter to a mux select for the chosen bit order.
  function automatic logic [CNT_W-1:0] bit_sel(input logic [CNT_W-1:0] cnt,
                                                input logic msb_first);
    return msb_first ? (CNT_MAX - cnt) : cnt;
  endfunction

endpackage

// File: rtl/mux_piso_serializer_if.sv
// Word-side and serial-side handshake bundle for the serializer.
interface mux_piso_serializer_if;
  import mux_piso_serializer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              ser_ready;
  logic              ser_valid;
  logic              ser_out;
  logic              ser_last;
  logic              busy;

  // Producer/consumer side: drives words in, accepts serial bits out.
  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last, busy
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last, busy
  );

endinterface

// File: rtl/mux_piso_serializer_mux8to1.sv
// Plain 8:1 single-bit multiplexer, input a selected by sel = 0.
module mux8to1 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       h,
  input  logic [2:0] sel,
  output logic       q
);

  // Route the selected input to q.
  always_comb begin
    q = a;
    case (sel)
      3'd0: q = a;
      3'd1: q = b;
      3'd2: q = c;
      3'd3: q = d;
      3'd4: q = e;
      3'd5: q = f;
      3'd6: q = g;
      3'd7: q = h;
      default: q = a;
    endcase
  end

endmodule

// File: rtl/mux_piso_serializer.sv
// Parallel-in/serial-out stage: takes an 8-bit word over valid/ready,
// walks the 8:1 mux across it with a 3-bit counter and registers the
// selected bit into a valid/ready/last serial stream.
module mux_piso_serializer
  import mux_piso_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux_piso_serializer_if.slave    bus
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_SHIFT = SHIFT;

  logic [0:0]        state;
  logic [WORD_W-1:0] data_reg;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  sel;
  logic              ser_out_r;
  logic              ser_valid_r;
  logic              ser_last_r;
  logic              adv;
  logic              accept;
  logic              at_last;
  logic              mux_q;

  // A bit moves out when shifting and the output slot is empty or draining.
  assign adv     = (state == S_SHIFT) && (!ser_valid_r || bus.ser_ready);
  assign at_last = (cnt == CNT_MAX);
  assign accept  = bus.in_valid && bus.in_ready;
  assign sel     = bit_sel(cnt, MSB_FIRST);

  assign bus.in_ready  = (state == S_IDLE) || (adv && at_last);
  assign bus.ser_out   = ser_out_r;
  assign bus.ser_valid = ser_valid_r;
  assign bus.ser_last  = ser_last_r;
  assign bus.busy      = (state == S_SHIFT);

  mux8to1 u_mux (
    .a   (data_reg[0]),
    .b   (data_reg[1]),
    .c   (data_reg[2]),
    .d   (data_reg[3]),
    .e   (data_reg[4]),
    .f   (data_reg[5]),
    .g   (data_reg[6]),
    .h   (data_reg[7]),
    .sel (sel),
    .q   (mux_q)
  );

  // Capture the word only on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (accept) begin
      data_reg <= bus.in_data;
    end
  end

  // FSM and bit counter; the counter wraps 7 -> 0 so a chained word starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (adv) begin
            cnt <= cnt + 1'b1;
            if (at_last && !bus.in_valid) begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Serial output register: load on advance, drain the final bit when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_out_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      ser_last_r  <= 1'b0;
    end else if (adv) begin
      ser_out_r   <= mux_q;
      ser_valid_r <= 1'b1;
      ser_last_r  <= at_last;
    end else if (state == S_IDLE && ser_valid_r && bus.ser_ready) begin
      ser_valid_r <= 1'b0;
      ser_last_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_piso_serializer.sv
// Directed bench for mux_piso_serializer: LSB-first and MSB-first
// instances share stimulus; expected bit streams are hand-computed.
module tb_mux_piso_serializer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux_piso_serializer_if a ();
  mux_piso_serializer_if b ();

  mux_piso_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  mux_piso_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    a.in_valid  = v;
    a.in_data   = d;
    a.ser_ready = r;
    b.in_valid  = v;
    b.in_data   = d;
    b.ser_ready = r;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  exp_lsb;
  logic [7:0]  exp_msb;
  logic [15:0] exp16;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    step();
    step();

    // Reset state
    chk("rst_valid", a.ser_valid, 1'b0);
    chk("rst_last", a.ser_last, 1'b0);
    chk("rst_out", a.ser_out, 1'b0);
    chk("rst_busy", a.busy, 1'b0);
    chk("rst_in_ready", a.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Single word 0xC1, both bit orders
    exp_lsb = 8'hC1;
    exp_msb = 8'h83;
    drive(1'b1, 8'hC1, 1'b1);
    chk("c1_in_ready", a.in_ready, 1'b1);
    step();
    drive(1'b0, 8'hFF, 1'b1);
    chk("c1_busy0", a.busy, 1'b1);
    chk("c1_valid0", a.ser_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("c1_lsb_bit%0d", i), a.ser_out, exp_lsb[i]);
      chk($sformatf("c1_msb_bit%0d", i), b.ser_out, exp_msb[i]);
      chk($sformatf("c1_valid%0d", i), a.ser_valid, 1'b1);
      chk($sformatf("c1_last%0d", i), a.ser_last, (i == 7));
      chk($sformatf("c1_msb_last%0d", i), b.ser_last, (i == 7));
      chk($sformatf("c1_busy%0d", i), a.busy, (i != 7));
      chk($sformatf("c1_in_ready%0d", i), a.in_ready, (i >= 6));
    end
    step();
    chk("c1_drain_valid", a.ser_valid, 1'b0);
    chk("c1_drain_last", a.ser_last, 1'b0);

    // Back-to-back 0xA0 then 0x05, no bubble
    exp16 = 16'h05A0;
    drive(1'b1, 8'hA0, 1'b1);
    step();
    drive(1'b1, 8'h05, 1'b1);
    chk("b2b_hold_ready", a.in_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("b2b_bit%0d", i), a.ser_out, exp16[i]);
      chk($sformatf("b2b_valid%0d", i), a.ser_valid, 1'b1);
      chk($sformatf("b2b_last%0d", i), a.ser_last, (i == 7 || i == 15));
      chk($sformatf("b2b_busy%0d", i), a.busy, (i != 15));
      chk($sformatf("b2b_in_ready%0d", i), a.in_ready, (i == 6 || i >= 14));
      if (i == 7) drive(1'b0, 8'h00, 1'b1);
    end
    step();
    chk("b2b_drain_valid", a.ser_valid, 1'b0);

    // Backpressure: 0x5A, stall three cycles on bit 2
    exp_lsb = 8'h5A;
    drive(1'b1, 8'h5A, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bp_bit%0d", i), a.ser_out, exp_lsb[i]);
      chk($sformatf("bp_last%0d", i), a.ser_last, (i == 7));
      if (i < 6) chk($sformatf("bp_in_ready%0d", i), a.in_ready, 1'b0);
      if (i == 2) begin
        drive(1'b0, 8'h00, 1'b0);
        for (int s = 0; s < 3; s++) begin
          step();
          chk($sformatf("bp_stall_bit%0d", s), a.ser_out, exp_lsb[2]);
          chk($sformatf("bp_stall_valid%0d", s), a.ser_valid, 1'b1);
          chk($sformatf("bp_stall_in_ready%0d", s), a.in_ready, 1'b0);
          chk($sformatf("bp_stall_busy%0d", s), a.busy, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b1);
      end
    end
    step();
    chk("bp_drain_valid", a.ser_valid, 1'b0);

    // Stall around the last bit with the next word waiting
    exp_lsb = 8'h3C;
    drive(1'b1, 8'h3C, 1'b1);
    step();
    drive(1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("sl_bit%0d", i), a.ser_out, exp_lsb[i]);
    end
    drive(1'b1, 8'h81, 1'b0);
    #1;
    chk("sl_cnt7_in_ready", a.in_ready, 1'b0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk($sformatf("sl_hold_in_ready%0d", s), a.in_ready, 1'b0);
      chk($sformatf("sl_hold_bit%0d", s), a.ser_out, exp_lsb[6]);
      chk($sformatf("sl_hold_last%0d", s), a.ser_last, 1'b0);
    end
    drive(1'b1, 8'h81, 1'b1);
    #1;
    chk("sl_release_in_ready", a.in_ready, 1'b1);
    step();
    chk("sl_bit7", a.ser_out, exp_lsb[7]);
    chk("sl_last7", a.ser_last, 1'b1);
    chk("sl_busy_next", a.busy, 1'b1);
    drive(1'b1, 8'h81, 1'b0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk($sformatf("sl_last_hold_in_ready%0d", s), a.in_ready, 1'b0);
      chk($sformatf("sl_last_hold_last%0d", s), a.ser_last, 1'b1);
      chk($sformatf("sl_last_hold_valid%0d", s), a.ser_valid, 1'b1);
    end
    exp_lsb = 8'h81;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("sl_next_bit%0d", i), a.ser_out, exp_lsb[i]);
      chk($sformatf("sl_next_last%0d", i), a.ser_last, (i == 7));
    end
    step();
    chk("sl_drain_valid", a.ser_valid, 1'b0);

    // Asynchronous reset in the middle of a word
    drive(1'b1, 8'hFF, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    step();
    step();
    chk("mid_pre_valid", a.ser_valid, 1'b1);
    chk("mid_pre_out", a.ser_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", a.ser_out, 1'b0);
    chk("mid_rst_valid", a.ser_valid, 1'b0);
    chk("mid_rst_last", a.ser_last, 1'b0);
    chk("mid_rst_busy", a.busy, 1'b0);
    chk("mid_rst_in_ready", a.in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_valid", a.ser_valid, 1'b0);
    chk("post_rst_busy", a.busy, 1'b0);
    chk("post_rst_in_ready", a.in_ready, 1'b1);
    chk("post_rst_out", a.ser_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
